// File: rtl/memory_pkg.sv
// Shared card-array types and picker state encoding
// for the memory game datapath.
package memory_pkg;

  localparam int N_CARDS = 16;
  localparam int CARD_W  = 5;
  localparam int IDX_W   = $clog2(N_CARDS);

  localparam logic [1:0] CARD_HIDDEN  = 2'b00;
  localparam logic [1:0] CARD_SHOWN   = 2'b01;
  localparam logic [1:0] CARD_MATCHED = 2'b10;

  typedef struct packed {
    logic [1:0] status;
    logic [2:0] pair_id;
  } card_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PICK1,
    ST_WAIT1,
    ST_PICK2,
    ST_WAIT2,
    ST_COMPARE,
    ST_RES_A,
    ST_RES_B,
    ST_UNDO
  } picker_state_e;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a synchronised button level;
// a held button yields a single event.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = btn;
    rise   = btn & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

endmodule

// File: rtl/card_picker.sv
// Player-input stage: cursor movement, two-card pick,
// pair compare and status-update requests to the array owner.
module card_picker
  import memory_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              timeout,
  input  logic              btn_izq,
  input  logic              btn_der,
  input  logic              btn_sel,
  input  logic [CARD_W-1:0] arr_cards [N_CARDS],
  input  logic              upd_ready,
  output logic              upd_valid,
  output logic [IDX_W-1:0]  upd_idx,
  output logic [1:0]        upd_status,
  output logic [IDX_W-1:0]  cursor,
  output logic [1:0]        sel_count,
  output logic              card_chosen,
  output logic              result_valid,
  output logic              result_match
);

  picker_state_e state_q, state_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [IDX_W-1:0] second_q, second_d;
  logic [1:0] cnt_q, cnt_d;
  logic match_q, match_d;

  logic izq_e, der_e, sel_e;
  logic cur_hidden, ids_eq, in_pick;

  btn_edge u_izq (.clk(clk), .rst(rst), .btn(btn_izq), .rise(izq_e));
  btn_edge u_der (.clk(clk), .rst(rst), .btn(btn_der), .rise(der_e));
  btn_edge u_sel (.clk(clk), .rst(rst), .btn(btn_sel), .rise(sel_e));

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    first_d  = first_q;
    second_d = second_q;
    cnt_d    = cnt_q;
    match_d  = match_q;

    upd_valid    = 1'b0;
    upd_idx      = '0;
    upd_status   = CARD_HIDDEN;
    card_chosen  = 1'b0;
    result_valid = 1'b0;
    result_match = 1'b0;

    cur_hidden = (arr_cards[cursor_q][4:3] == CARD_HIDDEN);
    ids_eq     = (arr_cards[first_q][2:0] == arr_cards[second_q][2:0]);
    in_pick    = (state_q == ST_PICK1) || (state_q == ST_PICK2);

    // selection below uses cursor_q, so a same-cycle move lands afterwards
    if (in_pick) begin
      if (izq_e && !der_e)      cursor_d = cursor_q - IDX_W'(1);
      else if (der_e && !izq_e) cursor_d = cursor_q + IDX_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = (cnt_q == 2'd0) ? ST_PICK1 : ST_PICK2;
      end
      ST_PICK1: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!timeout && sel_e && cur_hidden) begin
          first_d = cursor_q;
          state_d = ST_WAIT1;
        end
      end
      ST_WAIT1: begin
        upd_valid  = 1'b1;
        upd_idx    = first_q;
        upd_status = CARD_SHOWN;
        if (upd_ready) begin
          card_chosen = 1'b1;
          cnt_d       = 2'd1;
          state_d     = enable ? ST_PICK2 : ST_IDLE;
        end
      end
      ST_PICK2: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (timeout) begin
          state_d = ST_UNDO;
        end else if (sel_e && cur_hidden && cursor_q != first_q) begin
          second_d = cursor_q;
          state_d  = ST_WAIT2;
        end
      end
      ST_WAIT2: begin
        upd_valid  = 1'b1;
        upd_idx    = second_q;
        upd_status = CARD_SHOWN;
        if (upd_ready) begin
          card_chosen = 1'b1;
          cnt_d       = 2'd2;
          state_d     = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        result_valid = 1'b1;
        result_match = ids_eq;
        match_d      = ids_eq;
        state_d      = ST_RES_A;
      end
      ST_RES_A: begin
        upd_valid  = 1'b1;
        upd_idx    = first_q;
        upd_status = match_q ? CARD_MATCHED : CARD_HIDDEN;
        if (upd_ready) state_d = ST_RES_B;
      end
      ST_RES_B: begin
        upd_valid  = 1'b1;
        upd_idx    = second_q;
        upd_status = match_q ? CARD_MATCHED : CARD_HIDDEN;
        if (upd_ready) begin
          cnt_d   = 2'd0;
          state_d = enable ? ST_PICK1 : ST_IDLE;
        end
      end
      ST_UNDO: begin
        upd_valid  = 1'b1;
        upd_idx    = first_q;
        upd_status = CARD_HIDDEN;
        if (upd_ready) begin
          cnt_d   = 2'd0;
          state_d = enable ? ST_PICK1 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cursor    = cursor_q;
    sel_count = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cursor_q <= '0;
      first_q  <= '0;
      second_q <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      first_q  <= first_d;
      second_q <= second_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
    end
  end

endmodule

// File: tb/tb_card_picker.sv
// Directed bench for card_picker with a behavioural
// card-array owner and an update log.
module tb_card_picker;
  import memory_pkg::*;

  logic clk = 1'b0;
  logic rst, enable, timeout;
  logic btn_izq, btn_der, btn_sel;
  logic [CARD_W-1:0] cards [N_CARDS];
  logic upd_ready, upd_valid;
  logic [3:0] upd_idx, cursor;
  logic [1:0] upd_status, sel_count;
  logic card_chosen, result_valid, result_match;

  int n_cmp = 0;
  int n_err = 0;
  int n_chosen = 0;
  int n_res = 0;
  logic last_match = 1'b0;
  logic [5:0] log_q [$];
  int exp_cur = 0;

  always #5 clk = ~clk;

  card_picker dut (
    .clk(clk), .rst(rst), .enable(enable), .timeout(timeout),
    .btn_izq(btn_izq), .btn_der(btn_der), .btn_sel(btn_sel),
    .arr_cards(cards), .upd_ready(upd_ready),
    .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_status(upd_status), .cursor(cursor),
    .sel_count(sel_count), .card_chosen(card_chosen),
    .result_valid(result_valid), .result_match(result_match)
  );

  function automatic logic [2:0] init_id(int i);
    case (i)
      0: return 3'd3;
      5: return 3'd3;
      1: return 3'd2;
      4: return 3'd6;
      7: return 3'd1;
      default: return 3'(i + 1);
    endcase
  endfunction

  // owner model: accepts every handshake and applies the status
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CARDS; i++) cards[i] <= {CARD_HIDDEN, init_id(i)};
    end else begin
      if (upd_valid && upd_ready) begin
        cards[upd_idx][4:3] <= upd_status;
        log_q.push_back({upd_idx, upd_status});
      end
      if (card_chosen) n_chosen++;
      if (result_valid) begin
        n_res++;
        last_match = result_match;
      end
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_der();
    btn_der = 1'b1; cyc(1); btn_der = 1'b0; cyc(1);
    exp_cur = (exp_cur + 1) % 16;
  endtask

  task automatic press_izq();
    btn_izq = 1'b1; cyc(1); btn_izq = 1'b0; cyc(1);
    exp_cur = (exp_cur + 15) % 16;
  endtask

  task automatic press_sel();
    btn_sel = 1'b1; cyc(1); btn_sel = 1'b0; cyc(1);
  endtask

  task automatic move_to(int t);
    while (exp_cur != t) press_der();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; enable = 1'b0; timeout = 1'b0;
    btn_izq = 1'b0; btn_der = 1'b0; btn_sel = 1'b0;
    upd_ready = 1'b1;
    cyc(3);
    check("rst_cursor", 32'(cursor), 0);
    check("rst_valid", 32'(upd_valid), 0);
    check("rst_selcnt", 32'(sel_count), 0);
    check("rst_chosen", 32'(card_chosen), 0);
    check("rst_result", 32'(result_valid), 0);
    rst = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(1);

    repeat (3) press_der();
    press_izq();
    check("cur_3r1l", 32'(cursor), 2);
    press_izq(); press_izq();
    press_izq();
    check("cur_wrap_lo", 32'(cursor), 15);
    press_der();
    check("cur_wrap_hi", 32'(cursor), 0);
    repeat (16) press_der();
    check("cur_16r", 32'(cursor), 0);
    btn_izq = 1'b1; btn_der = 1'b1; cyc(1);
    btn_izq = 1'b0; btn_der = 1'b0; cyc(1);
    check("cur_both", 32'(cursor), 0);

    log_q.delete(); c0 = n_chosen;
    move_to(0); press_sel();
    check("p1_selcnt", 32'(sel_count), 1);
    move_to(5); press_sel();
    cyc(6);
    check("m_log_n", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("m_log0", 32'(log_q[0]), {4'd0, 2'b01});
      check("m_log1", 32'(log_q[1]), {4'd5, 2'b01});
      check("m_log2", 32'(log_q[2]), {4'd0, 2'b10});
      check("m_log3", 32'(log_q[3]), {4'd5, 2'b10});
    end
    check("m_chosen", n_chosen - c0, 2);
    check("m_res_n", n_res, 1);
    check("m_match", 32'(last_match), 1);
    check("m_selcnt", 32'(sel_count), 0);

    log_q.delete(); c0 = n_chosen;
    move_to(1); press_sel();
    move_to(4); press_sel();
    cyc(6);
    check("n_log_n", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("n_log2", 32'(log_q[2]), {4'd1, 2'b00});
      check("n_log3", 32'(log_q[3]), {4'd4, 2'b00});
    end
    check("n_chosen", n_chosen - c0, 2);
    check("n_res_n", n_res, 2);
    check("n_match", 32'(last_match), 0);

    log_q.delete(); c0 = n_chosen;
    move_to(7);
    upd_ready = 1'b0;
    press_sel();
    for (int k = 0; k < 5; k++) begin
      check("st_valid", 32'(upd_valid), 1);
      check("st_idx", 32'(upd_idx), 7);
      check("st_status", 32'(upd_status), 1);
      check("st_chosen", 32'(card_chosen), 0);
      cyc(1);
    end
    upd_ready = 1'b1;
    #1;
    check("st_hs_pulse", 32'(card_chosen), 1);
    cyc(1);
    check("st_selcnt", 32'(sel_count), 1);
    check("st_valid_off", 32'(upd_valid), 0);

    log_q.delete(); c0 = n_chosen;
    press_sel();
    move_to(0); press_sel();
    cyc(2);
    check("ign_log", log_q.size(), 0);
    check("ign_chosen", n_chosen - c0, 0);

    timeout = 1'b1; cyc(1); timeout = 1'b0;
    cyc(3);
    check("to_log_n", log_q.size(), 1);
    if (log_q.size() == 1)
      check("to_log0", 32'(log_q[0]), {4'd7, 2'b00});
    check("to_selcnt", 32'(sel_count), 0);

    log_q.delete(); c0 = n_chosen;
    press_sel();
    cyc(1);
    check("p1_ign_log", log_q.size(), 0);
    move_to(2); press_sel();
    check("p1_chosen", n_chosen - c0, 1);
    check("p1_selcnt2", 32'(sel_count), 1);
    check("p1_log_n", log_q.size(), 1);
    if (log_q.size() == 1)
      check("p1_log0", 32'(log_q[0]), {4'd2, 2'b01});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
